prog_loader: RTL and testbench

//  Byte-stream program loader. Writes a program into the CPU instruction memory and drives
//  cpu_rst, the active-high reset that top forwards to the datapath. It drives the CPU,

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/loader_timeout.sv | 32 +++
 rtl/prog_loader.sv | 185 ++++++++++++++++++
 tb/tb_prog_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU slice: datapath widths, the loader sync
// byte, the loader state encoding and a small width helper.
package cpu_pkg;

  localparam int DEF_INSTR_W = 16;
  localparam int DEF_ADDR_W  = 8;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    WR   = 3'd3,
    CHK  = 3'd4,
    RUN  = 3'd5,
    ERR  = 3'd6
  } state_t;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte gap timer for the program loader. Counts consecutive enabled
// cycles; expired is high on the LIMIT-th consecutive enabled cycle.
module loader_timeout
  import cpu_pkg::*;
#(
  parameter int LIMIT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = cnt_w(LIMIT);

  logic [CW-1:0] cnt;

  assign expired = en && (cnt == CW'(LIMIT - 1));

  // Gap counter: cleared by reset or clr, advances on each enabled cycle.
  // NOTE: the reset is synchronous, so it is tested inside the clocked block
  // and only clk appears in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader. Holds the CPU in reset while a packet
// (sync, length, big-endian instruction words, 8-bit additive checksum)
// is written into instruction memory, then releases the CPU on a good
// checksum. Any framing, checksum or gap-timeout error keeps the CPU held.
module prog_loader
  import cpu_pkg::*;
#(
  parameter int INSTR_W     = DEF_INSTR_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int TIMEOUT_CYC = 1000,
  parameter bit BOOT_RUN    = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_rst,
  output logic               load_done,
  output logic               load_err,
  output logic [ADDR_W:0]    words_loaded
);

  localparam int BPW = INSTR_W / 8;
  localparam int BCW = cnt_w(BPW);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);

  state_t             state;
  state_t             state_next;
  logic [7:0]         len;
  logic [BCW-1:0]     byte_cnt;
  logic [INSTR_W-1:0] word;
  logic [INSTR_W-1:0] word_next;
  logic [7:0]         sum;
  logic [ADDR_W-1:0]  addr;

  logic xfer;
  logic is_sync;
  logic last_byte;
  logic last_word;
  logic in_packet;
  logic expired;

  assign xfer      = in_valid && in_ready;
  assign is_sync   = (in_data == SYNC_BYTE);
  assign last_byte = (byte_cnt == LAST_BYTE);
  assign last_word = ((words_loaded + 1'b1) == (ADDR_W + 1)'(len));
  assign in_packet = (state == LEN) || (state == DATA) || (state == CHK);
  assign word_next = (word << 8) | INSTR_W'(in_data);

  loader_timeout #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (!in_packet || xfer),
    .en      (in_packet && !xfer),
    .expired (expired)
  );

  // State register; the boot mode decides whether reset lands in RUN or IDLE.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= BOOT_RUN ? RUN : IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic for the packet framing.
  // NOTE: the default is assigned before the case so no path leaves
  // state_next unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, RUN, ERR: begin
        if (xfer && is_sync) state_next = LEN;
      end
      LEN: begin
        if (xfer)         state_next = (in_data == 8'd0) ? ERR : DATA;
        else if (expired) state_next = ERR;
      end
      DATA: begin
        if (xfer) begin
          if (last_byte) state_next = WR;
        end else if (expired) begin
          state_next = ERR;
        end
      end
      WR: begin
        state_next = last_word ? CHK : DATA;
      end
      CHK: begin
        if (xfer)         state_next = (in_data == sum) ? RUN : ERR;
        else if (expired) state_next = ERR;
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs, word assembler, checksum and write address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_ready     <= 1'b1;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_rst      <= ~BOOT_RUN;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
      len          <= '0;
      byte_cnt     <= '0;
      word         <= '0;
      sum          <= '0;
      addr         <= '0;
    end else begin
      imem_we  <= 1'b0;
      in_ready <= (state_next != WR);
      unique case (state)
        IDLE, RUN, ERR: begin
          if (xfer && is_sync) begin
            cpu_rst      <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
            addr         <= '0;
            sum          <= '0;
          end
        end
        LEN: begin
          if (xfer) begin
            if (in_data == 8'd0) begin
              load_err <= 1'b1;
            end else begin
              len      <= in_data;
              byte_cnt <= '0;
            end
          end else if (expired) begin
            load_err <= 1'b1;
          end
        end
        DATA: begin
          if (xfer) begin
            word <= word_next;
            sum  <= sum + in_data;
            if (last_byte) begin
              imem_we    <= 1'b1;
              imem_addr  <= addr;
              imem_wdata <= word_next;
              byte_cnt   <= '0;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else if (expired) begin
            load_err <= 1'b1;
          end
        end
        WR: begin
          addr         <= addr + 1'b1;
          words_loaded <= words_loaded + 1'b1;
        end
        CHK: begin
          if (xfer) begin
            if (in_data == sum) begin
              cpu_rst   <= 1'b0;
              load_done <= 1'b1;
            end else begin
              load_err <= 1'b1;
            end
          end else if (expired) begin
            load_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good load, checksum error and recovery,
// zero length, gap timeout, reload while running, streaming backpressure,
// reset mid-load, plus a boot-run instance sharing the same byte stream.
module tb_prog_loader;
  import cpu_pkg::*;

  localparam int TIMEOUT = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_rst;
  logic        load_done;
  logic        load_err;
  logic [8:0]  words_loaded;

  logic        in_ready_b;
  logic        imem_we_b;
  logic [7:0]  imem_addr_b;
  logic [15:0] imem_wdata_b;
  logic        cpu_rst_b;
  logic        load_done_b;
  logic        load_err_b;
  logic [8:0]  words_loaded_b;

  int checks = 0;
  int errors = 0;

  logic [7:0]  wr_addr [16];
  logic [15:0] wr_data [16];
  int          wr_cnt = 0;

  always #5 clk = ~clk;

  prog_loader #(
    .INSTR_W(16), .ADDR_W(8), .TIMEOUT_CYC(TIMEOUT), .BOOT_RUN(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .load_done(load_done),
    .load_err(load_err), .words_loaded(words_loaded)
  );

  prog_loader #(
    .INSTR_W(16), .ADDR_W(8), .TIMEOUT_CYC(TIMEOUT), .BOOT_RUN(1'b1)
  ) dut_boot (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_b), .imem_we(imem_we_b), .imem_addr(imem_addr_b),
    .imem_wdata(imem_wdata_b), .cpu_rst(cpu_rst_b), .load_done(load_done_b),
    .load_err(load_err_b), .words_loaded(words_loaded_b)
  );

  // Record every imem write, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we && wr_cnt < 16) begin
      wr_addr[wr_cnt] = imem_addr;
      wr_data[wr_cnt] = imem_wdata;
      wr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one byte; called and returns at posedge+1.
  task automatic send(input logic [7:0] b);
    int waits = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waits < 8) begin
      @(posedge clk); #1;
      waits++;
    end
    if (waits >= 8) check("ready_wait", 32'(waits), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  logic [7:0] stream [7];
  int idx;
  int stalls;
  int bad;
  int guard;

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // 1: reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_words", 32'(words_loaded), 32'd0);
    check("rst_boot_cpu_rst", 32'(cpu_rst_b), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // 2: good two-word load, checksum 12+34+AB+CD = 1BE -> BE
    send(8'hA5);
    check("boot_reload_cpu_rst", 32'(cpu_rst_b), 32'd1);
    send(8'h02);
    send(8'h12);
    send(8'h34);
    send(8'hAB);
    send(8'hCD);
    check("wr_cycle_in_ready", 32'(in_ready), 32'd0);
    check("wr_cycle_we", 32'(imem_we), 32'd1);
    check("wr_cycle_addr", 32'(imem_addr), 32'd1);
    check("wr_cycle_data", 32'(imem_wdata), 32'hABCD);
    check("pre_chk_cpu_rst", 32'(cpu_rst), 32'd1);
    send(8'hBE);
    check("good_wr_cnt", 32'(wr_cnt), 32'd2);
    check("good_wr0_addr", 32'(wr_addr[0]), 32'd0);
    check("good_wr0_data", 32'(wr_data[0]), 32'h1234);
    check("good_wr1_addr", 32'(wr_addr[1]), 32'd1);
    check("good_wr1_data", 32'(wr_data[1]), 32'hABCD);
    check("good_words", 32'(words_loaded), 32'd2);
    check("good_done", 32'(load_done), 32'd1);
    check("good_err", 32'(load_err), 32'd0);
    check("good_cpu_rst", 32'(cpu_rst), 32'd0);

    // 3: bad checksum (expect 46, send 00), then recovery with 56 78 CE
    send(8'hA5); send(8'h01); send(8'h12); send(8'h34); send(8'h00);
    check("bad_wr_cnt", 32'(wr_cnt), 32'd3);
    check("bad_wr2_data", 32'(wr_data[2]), 32'h1234);
    check("bad_err", 32'(load_err), 32'd1);
    check("bad_done", 32'(load_done), 32'd0);
    check("bad_cpu_rst", 32'(cpu_rst), 32'd1);
    send(8'hA5); send(8'h01); send(8'h56); send(8'h78); send(8'hCE);
    check("recov_wr3_data", 32'(wr_data[3]), 32'h5678);
    check("recov_done", 32'(load_done), 32'd1);
    check("recov_err", 32'(load_err), 32'd0);
    check("recov_cpu_rst", 32'(cpu_rst), 32'd0);

    // 5: stray bytes while running are dropped; A5 reloads
    send(8'h11); send(8'h22);
    check("stray_cpu_rst", 32'(cpu_rst), 32'd0);
    check("stray_done", 32'(load_done), 32'd1);
    check("stray_words", 32'(words_loaded), 32'd1);
    check("stray_wr_cnt", 32'(wr_cnt), 32'd4);
    send(8'hA5);
    check("reload_cpu_rst", 32'(cpu_rst), 32'd1);
    check("reload_done", 32'(load_done), 32'd0);
    check("reload_words", 32'(words_loaded), 32'd0);

    // 4a: zero length
    send(8'h00);
    check("len0_err", 32'(load_err), 32'd1);
    check("len0_cpu_rst", 32'(cpu_rst), 32'd1);
    check("len0_wr_cnt", 32'(wr_cnt), 32'd4);

    // 4b: gap timeout after a partial word
    send(8'hA5); send(8'h01); send(8'h12);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    check("tmo_not_yet", 32'(load_err), 32'd0);
    @(posedge clk); #1;
    check("tmo_err", 32'(load_err), 32'd1);
    check("tmo_cpu_rst", 32'(cpu_rst), 32'd1);
    check("tmo_wr_cnt", 32'(wr_cnt), 32'd4);

    // 6a: streaming with in_valid held high; in_ready drops only in WR
    stream[0] = 8'hA5; stream[1] = 8'h02; stream[2] = 8'h12; stream[3] = 8'h34;
    stream[4] = 8'hAB; stream[5] = 8'hCD; stream[6] = 8'hBE;
    idx = 0; stalls = 0; bad = 0; guard = 0;
    in_valid = 1'b1;
    while (idx < 7 && guard < 40) begin
      in_data = stream[idx];
      if (in_ready == imem_we) bad++;
      if (in_ready) idx++;
      else stalls++;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    check("stream_complete", 32'(idx), 32'd7);
    check("stream_stalls", 32'(stalls), 32'd2);
    check("stream_ready_vs_wr", 32'(bad), 32'd0);
    check("stream_done", 32'(load_done), 32'd1);
    check("stream_wr_cnt", 32'(wr_cnt), 32'd6);

    // 6b: reset in the middle of the second word
    send(8'hA5); send(8'h02); send(8'h12); send(8'h34); send(8'h56);
    check("mid_words", 32'(words_loaded), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h78;
    reset    = 1'b0;
    @(posedge clk); #1;
    check("midrst_state", 32'(dut.state), 32'(IDLE));
    check("midrst_words", 32'(words_loaded), 32'd0);
    check("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_we", 32'(imem_we), 32'd0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("post_rst_state", 32'(dut.state), 32'(IDLE));
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("final_wr_cnt", 32'(wr_cnt), 32'd7);
    check("final_wr6_data", 32'(wr_data[6]), 32'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
